// File: rtl/serial_subtractor_n_bit.sv
// serial_subtractor_n_bit: LSB-first bit-serial subtractor with start/done handshake
module serial_subtractor_n_bit #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] in_a,
  input  logic [size-1:0] in_b,
  output logic [size-1:0] out,
  output logic            bout,
  output logic            zero,
  output logic            busy,
  output logic            done
);
  localparam int cw = $clog2(size);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [cw-1:0] cnt;
  logic [size-1:0] a_sr, b_sr, diff, diff_n;
  logic brw, d, brw_n, last, accept;
  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ brw;
    brw_n  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    diff_n = {d, diff[size-1:1]};
    last   = cnt == cw'(size - 1);
    accept = start && state != RUN;
    next   = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy   = state == RUN;
    done   = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      diff <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      out  <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      a_sr <= in_a;
      b_sr <= in_b;
      diff <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      diff <= diff_n;
      brw  <= brw_n;
      cnt  <= cnt + cw'(1);
      if (last) begin
        out  <= diff_n;
        bout <= brw_n;
        zero <= diff_n == '0;
      end
    end
  end
endmodule
